// File: rtl/seq_mult.sv
// Sequential shift-add multiplier. It handles signed or unsigned operands,
// takes one multiplier bit per cycle, and uses a valid/ready handshake on
// both the operand side and the result side.
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic              sign_q, sign_d;
  logic [PW-1:0]     c_q, c_d;
  logic [PW-1:0]     acc_sum;

  // Unsigned magnitude of an operand. The most negative value maps to
  // 2^(WIDTH-1), and that still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic signed_mode);
    return (signed_mode && x[WIDTH-1]) ? (-x) : x;
  endfunction

  // Re-applies the recorded result sign, wrapping mod 2^(2*WIDTH).
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                               input logic neg);
    return neg ? (-mag) : mag;
  endfunction

  // The multiplicand is pre-shifted, so each iteration adds it at a fixed
  // position and no barrel shifter is needed.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state logic and datapath updates for the accept/iterate/drain sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    c_d      = c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, magnitude(a, is_signed)};
          mplier_d = magnitude(b, is_signed);
          sign_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Always run all WIDTH iterations, so latency does not depend on the data.
        if (cnt_q == LAST_ITER) begin
          c_d     = apply_sign(acc_sum, sign_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      c_q      <= c_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign c         = c_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult at WIDTH = 16, 8 and 5. Every result is compared with
// an arithmetic product computed by the bench itself.
module tb_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  is_sg;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [4:0]  a5, b5;

  logic        rdy16, ov16, bsy16;
  logic        rdy8, ov8, bsy8;
  logic        rdy5, ov5, bsy5;
  logic [31:0] c16;
  logic [15:0] c8;
  logic [9:0]  c5;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid[0]), .in_ready(rdy16),
    .a(a16), .b(b16), .is_signed(is_sg[0]), .out_valid(ov16),
    .out_ready(out_ready[0]), .c(c16), .busy(bsy16));

  seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid[1]), .in_ready(rdy8),
    .a(a8), .b(b8), .is_signed(is_sg[1]), .out_valid(ov8),
    .out_ready(out_ready[1]), .c(c8), .busy(bsy8));

  seq_mult #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid[2]), .in_ready(rdy5),
    .a(a5), .b(b5), .is_signed(is_sg[2]), .out_valid(ov5),
    .out_ready(out_ready[2]), .c(c5), .busy(bsy5));

  function automatic logic rdy(input int s);
    case (s)
      0: return rdy16;
      1: return rdy8;
      default: return rdy5;
    endcase
  endfunction

  function automatic logic ov(input int s);
    case (s)
      0: return ov16;
      1: return ov8;
      default: return ov5;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      0: return bsy16;
      1: return bsy8;
      default: return bsy5;
    endcase
  endfunction

  function automatic logic [63:0] cval(input int s);
    case (s)
      0: return 64'(c16);
      1: return 64'(c8);
      default: return 64'(c5);
    endcase
  endfunction

  // Reference: interpret operands as integers and multiply, then wrap.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] av,
                                           input logic [31:0] bv, input logic sg);
    longint one = 1;
    longint sa, sb, p;
    sa = longint'(av) & ((one << w) - 1);
    sb = longint'(bv) & ((one << w) - 1);
    if (sg && sa[w-1]) sa = sa - (one << w);
    if (sg && sb[w-1]) sb = sb - (one << w);
    p = sa * sb;
    return 64'(p) & ((64'h1 << (2 * w)) - 64'h1);
  endfunction

  task automatic set_ops(input int s, input logic [31:0] av, input logic [31:0] bv,
                         input logic sg);
    case (s)
      0: begin a16 = av[15:0]; b16 = bv[15:0]; end
      1: begin a8 = av[7:0]; b8 = bv[7:0]; end
      default: begin a5 = av[4:0]; b5 = bv[4:0]; end
    endcase
    is_sg[s] = sg;
  endtask

  // Runs one transaction and drains it. lat is the number of rising edges
  // from the accepting edge to out_valid, or -1 if out_valid never came.
  task automatic drive_txn(input int s, input logic [31:0] av, input logic [31:0] bv,
                           input logic sg, output logic [63:0] c_got, output int lat);
    int k;
    lat = -1;
    c_got = '0;
    @(negedge clk);
    k = 0;
    while (!rdy(s) && k < 50) begin
      @(negedge clk);
      k++;
    end
    set_ops(s, av, bv, sg);
    in_valid[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[s] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov(s)) begin
        lat = e;
        break;
      end
    end
    c_got = cval(s);
    out_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    is_sg = '0;
    set_ops(0, 0, 0, 0);
    set_ops(1, 0, 0, 0);
    set_ops(2, 0, 0, 0);
    #12;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (rdy(s) !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready[%0d] got %b want 1", s, rdy(s));
      end
      n_cmp++;
      if (ov(s) !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_out_valid[%0d] got %b want 0", s, ov(s));
      end
      n_cmp++;
      if (bsy(s) !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_busy[%0d] got %b want 0", s, bsy(s));
      end
      n_cmp++;
      if (cval(s) !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_c[%0d] got %h want 0", s, cval(s));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    logic [63:0] cg;
    int lat;
    drive_txn(0, 32'hFFFF, 32'hFFFF, 1'b0, cg, lat);
    n_cmp++;
    if (cg !== 64'hFFFE0001) begin
      n_bad++;
      $display("FAIL unsigned_max_c got %h want fffe0001", cg);
    end
    n_cmp++;
    if (lat != 16) begin
      n_bad++;
      $display("FAIL unsigned_max_latency got %0d want 16", lat);
    end
  endtask

  task automatic test_mode_select();
    logic [63:0] cg;
    int lat;
    drive_txn(0, 32'hFFFF, 32'h0002, 1'b1, cg, lat);
    n_cmp++;
    if (cg !== 64'hFFFFFFFE) begin
      n_bad++;
      $display("FAIL mode_signed_c got %h want fffffffe", cg);
    end
    drive_txn(0, 32'hFFFF, 32'h0002, 1'b0, cg, lat);
    n_cmp++;
    if (cg !== 64'h0001FFFE) begin
      n_bad++;
      $display("FAIL mode_unsigned_c got %h want 0001fffe", cg);
    end
  endtask

  task automatic test_signed_corner();
    logic [63:0] cg;
    int lat;
    drive_txn(0, 32'h8000, 32'h8000, 1'b1, cg, lat);
    n_cmp++;
    if (cg !== 64'h40000000) begin
      n_bad++;
      $display("FAIL min_times_min got %h want 40000000", cg);
    end
    drive_txn(0, 32'h8000, 32'h0001, 1'b1, cg, lat);
    n_cmp++;
    if (cg !== 64'hFFFF8000) begin
      n_bad++;
      $display("FAIL min_times_one got %h want ffff8000", cg);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] c0, cg, exp0;
    int lat;
    bit seen;
    logic [31:0] av, bv;
    av = $urandom & 32'hFFFF;
    bv = $urandom & 32'hFFFF;
    exp0 = ref_prod(16, av, bv, 1'b1);
    @(negedge clk);
    set_ops(0, av, bv, 1'b1);
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    seen = 0;
    for (int e = 1; e <= 40 && !seen; e++) begin
      @(posedge clk);
      @(negedge clk);
      seen = ov(0);
    end
    c0 = cval(0);
    n_cmp++;
    if (!seen || c0 !== exp0) begin
      n_bad++;
      $display("FAIL bp_first_result got %h (valid %0d) want %h", c0, seen, exp0);
    end
    for (int i = 0; i < 5; i++) begin
      set_ops(0, $urandom, $urandom, 1'b0);
      in_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ov(0) !== 1'b1 || cval(0) !== c0 || rdy(0) !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d got ov=%b c=%h rdy=%b want ov=1 c=%h rdy=0",
                 i, ov(0), cval(0), rdy(0), c0);
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    n_cmp++;
    if (ov(0) !== 1'b0 || rdy(0) !== 1'b1 || cval(0) !== c0) begin
      n_bad++;
      $display("FAIL bp_release got ov=%b rdy=%b c=%h want ov=0 rdy=1 c=%h",
               ov(0), rdy(0), cval(0), c0);
    end
    drive_txn(0, 32'h0123, 32'h0456, 1'b0, cg, lat);
    n_cmp++;
    if (cg !== 64'h0004EDC2) begin
      n_bad++;
      $display("FAIL bp_next_txn got %h want 0004edc2", cg);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [63:0] exp2;
    bit seen;
    exp2 = ref_prod(16, 32'hAAAA, 32'h5555, 1'b1);
    @(negedge clk);
    set_ops(0, 32'd3, 32'd5, 1'b0);
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_ops(0, 32'hAAAA, 32'h5555, 1'b1);
    seen = 0;
    for (int e = 1; e <= 40 && !seen; e++) begin
      @(posedge clk);
      @(negedge clk);
      seen = ov(0);
    end
    n_cmp++;
    if (!seen || cval(0) !== 64'd15) begin
      n_bad++;
      $display("FAIL ignore_busy_inputs got %h (valid %0d) want f", cval(0), seen);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    n_cmp++;
    if (rdy(0) !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_to_idle in_ready got %b want 1", rdy(0));
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n_cmp++;
    if (bsy(0) !== 1'b1 || rdy(0) !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back_accept got busy=%b rdy=%b want busy=1 rdy=0", bsy(0), rdy(0));
    end
    seen = 0;
    for (int e = 1; e <= 40 && !seen; e++) begin
      @(posedge clk);
      @(negedge clk);
      seen = ov(0);
    end
    n_cmp++;
    if (!seen || cval(0) !== exp2) begin
      n_bad++;
      $display("FAIL back_to_back_result got %h (valid %0d) want %h", cval(0), seen, exp2);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ov_seen;
    @(negedge clk);
    set_ops(0, 32'hFFFF, 32'hFFFF, 1'b0);
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bsy(0) !== 1'b0 || cval(0) !== 64'h0 || rdy(0) !== 1'b1 || ov(0) !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got busy=%b c=%h rdy=%b ov=%b want 0/0/1/0",
               bsy(0), cval(0), rdy(0), ov(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (ov(0) || !rdy(0)) ov_seen++;
    end
    n_cmp++;
    if (ov_seen != 0) begin
      n_bad++;
      $display("FAIL mid_reset_aborted got %0d cycles with activity want 0", ov_seen);
    end
  endtask

  task automatic test_width8();
    logic [63:0] cg;
    int lat;
    drive_txn(1, 32'h7F, 32'h81, 1'b1, cg, lat);
    n_cmp++;
    if (cg !== 64'hC0FF) begin
      n_bad++;
      $display("FAIL w8_signed got %h want c0ff", cg);
    end
    n_cmp++;
    if (lat != 8) begin
      n_bad++;
      $display("FAIL w8_latency got %0d want 8", lat);
    end
  endtask

  task automatic test_random(input int s, input int w, input int n);
    logic [63:0] cg, exp;
    logic [31:0] av, bv, mask;
    logic sg;
    int lat;
    mask = 32'((64'h1 << w) - 1);
    for (int i = 0; i < n; i++) begin
      av = $urandom & mask;
      bv = $urandom & mask;
      case ($urandom_range(0, 7))
        0: av = 32'h1 << (w - 1);
        1: bv = mask;
        2: av = '0;
        default: ;
      endcase
      sg = 1'($urandom_range(0, 1));
      exp = ref_prod(w, av, bv, sg);
      drive_txn(s, av, bv, sg, cg, lat);
      n_cmp++;
      if (cg !== exp || lat != w) begin
        n_bad++;
        $display("FAIL random_w%0d a=%h b=%h s=%b got c=%h lat=%0d want c=%h lat=%0d",
                 w, av, bv, sg, cg, lat, exp, w);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_mode_select();
    test_signed_corner();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid();
    test_width8();
    test_random(0, 16, 500);
    test_random(2, 5, 500);
    test_random(1, 8, 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
